// File: rtl/handshake_const_matcher.sv
// Compares each accepted token against CONST_VALUE and emits a match-tagged control token; 1-cycle latency.
// A 2-entry skid buffer sustains full throughput, and ins_ready is a registered !skid_valid, so outs_ready has no combinational path to ins_ready.
module handshake_const_matcher #(
  parameter int unsigned                 DATA_WIDTH  = 32,
  parameter logic [DATA_WIDTH-1:0]       CONST_VALUE = DATA_WIDTH'(17'h1FBE7),
  parameter int unsigned                 CNT_WIDTH   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] ins,
  input  logic                  ins_valid,
  output logic                  ins_ready,
  output logic                  outs_valid,
  input  logic                  outs_ready,
  output logic                  outs_match,
  output logic [CNT_WIDTH-1:0]  mismatch_count,
  output logic                  error_sticky
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  state_t state;
  logic   skid_match;
  logic   accept;
  logic   xfer;
  logic   m;

  assign accept = ins_valid & ins_ready;
  assign xfer   = outs_valid & outs_ready;
  assign m      = (ins == CONST_VALUE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= ST_EMPTY;
      ins_ready      <= 1'b1;
      outs_valid     <= 1'b0;
      outs_match     <= 1'b0;
      skid_match     <= 1'b0;
      mismatch_count <= '0;
      error_sticky   <= 1'b0;
    end else begin
      // Statistics track accepted tokens, independent of when they drain.
      if (accept && !m) begin
        error_sticky <= 1'b1;
        if (mismatch_count != CNT_MAX)
          mismatch_count <= mismatch_count + 1'b1;
      end

      case (state)
        ST_EMPTY: begin
          if (accept) begin
            outs_match <= m;
            outs_valid <= 1'b1;
            state      <= ST_ONE;
          end
        end
        ST_ONE: begin
          if (accept && !xfer) begin
            skid_match <= m;
            ins_ready  <= 1'b0;
            state      <= ST_FULL;
          end else if (accept && xfer) begin
            outs_match <= m;
          end else if (xfer) begin
            outs_valid <= 1'b0;
            state      <= ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (xfer) begin
            outs_match <= skid_match;
            ins_ready  <= 1'b1;
            state      <= ST_ONE;
          end
        end
        default: begin
          state      <= ST_EMPTY;
          ins_ready  <= 1'b1;
          outs_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_handshake_const_matcher.sv
// Bench for handshake_const_matcher: a queue-based token model checked every cycle, plus directed literal expectations.
module tb_handshake_const_matcher;

  localparam logic [31:0] K = 32'h0001FBE7;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] ins = '0;
  logic        ins_valid = 1'b0;
  logic        ins_ready;
  logic        outs_valid;
  logic        outs_ready = 1'b0;
  logic        outs_match;
  logic [7:0]  mismatch_count;
  logic        error_sticky;

  int tests = 0;
  int fails = 0;

  handshake_const_matcher #(
    .DATA_WIDTH (32),
    .CONST_VALUE(32'h0001FBE7),
    .CNT_WIDTH  (8)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .ins           (ins),
    .ins_valid     (ins_valid),
    .ins_ready     (ins_ready),
    .outs_valid    (outs_valid),
    .outs_ready    (outs_ready),
    .outs_match    (outs_match),
    .mismatch_count(mismatch_count),
    .error_sticky  (error_sticky)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: tokens in flight are a queue of match flags, capacity two.
  bit q[$];
  int mism    = 0;
  int acc_cnt = 0;
  bit chk_en  = 0;
  bit m_acc, m_pop;

  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      mism   = 0;
      chk_en = 1;
    end else begin
      m_acc = ins_valid && (q.size() < 2);
      m_pop = outs_ready && (q.size() > 0);
      if (m_pop) void'(q.pop_front());
      if (m_acc) begin
        q.push_back(ins == K);
        acc_cnt++;
        if (ins != K) mism++;
      end
    end
  end

  int emitted = 0;
  bit prev_stall = 0;
  bit prev_m = 0;

  always @(negedge clk) begin
    if (chk_en && !rst) begin
      chk("ins_ready", 32'(ins_ready), 32'(q.size() < 2));
      chk("outs_valid", 32'(outs_valid), 32'(q.size() > 0));
      if (q.size() > 0) chk("outs_match", 32'(outs_match), 32'(q[0]));
      chk("mismatch_count", 32'(mismatch_count), (mism > 255) ? 32'd255 : 32'(mism));
      chk("error_sticky", 32'(error_sticky), 32'(mism > 0));
      if (prev_stall) begin
        chk("stall_valid", 32'(outs_valid), 32'd1);
        chk("stall_match", 32'(outs_match), 32'(prev_m));
      end
      if (outs_valid && outs_ready) emitted++;
    end
    prev_stall = outs_valid && !outs_ready && !rst;
    prev_m     = outs_match;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  initial begin
    int e0;
    int cycles;

    // Reset state
    rst = 1; cyc(); cyc(); rst = 0;
    chk("rst_ins_ready", 32'(ins_ready), 32'd1);
    chk("rst_outs_valid", 32'(outs_valid), 32'd0);
    chk("rst_outs_match", 32'(outs_match), 32'd0);
    chk("rst_count", 32'(mismatch_count), 32'd0);
    chk("rst_sticky", 32'(error_sticky), 32'd0);

    // Single matching token
    ins = K; ins_valid = 1; outs_ready = 1; cyc(); ins_valid = 0;
    chk("t1_valid", 32'(outs_valid), 32'd1);
    chk("t1_match", 32'(outs_match), 32'd1);
    chk("t1_count", 32'(mismatch_count), 32'd0);
    chk("t1_sticky", 32'(error_sticky), 32'd0);
    cyc();
    chk("t1_drained", 32'(outs_valid), 32'd0);

    // Single mismatching token
    ins = 32'h0001FBE6; ins_valid = 1; cyc(); ins_valid = 0;
    chk("t2_match", 32'(outs_match), 32'd0);
    chk("t2_count", 32'(mismatch_count), 32'd1);
    chk("t2_sticky", 32'(error_sticky), 32'd1);
    cyc();

    // Stall: match, mismatch, match
    outs_ready = 0;
    ins = K; ins_valid = 1; cyc();
    chk("t3_rdy_a", 32'(ins_ready), 32'd1);
    ins = K ^ 32'h1; cyc();
    chk("t3_rdy_b", 32'(ins_ready), 32'd0);
    chk("t3_head", 32'(outs_match), 32'd1);
    ins = K; cyc(); cyc();
    chk("t3_hold_rdy", 32'(ins_ready), 32'd0);
    chk("t3_hold_match", 32'(outs_match), 32'd1);
    chk("t3_count", 32'(mismatch_count), 32'd2);
    outs_ready = 1; cyc();
    chk("t3_pop1_match", 32'(outs_match), 32'd0);
    chk("t3_pop1_rdy", 32'(ins_ready), 32'd1);
    cyc(); ins_valid = 0;
    chk("t3_pop2_match", 32'(outs_match), 32'd1);
    chk("t3_pop2_valid", 32'(outs_valid), 32'd1);
    cyc();
    chk("t3_empty", 32'(outs_valid), 32'd0);

    // 300 mismatches at full rate
    e0 = emitted;
    ins = 32'h0; ins_valid = 1;
    for (int i = 0; i < 300; i++) cyc();
    ins_valid = 0; cyc();
    chk("t4_emitted", 32'(emitted - e0), 32'd300);
    chk("t4_count", 32'(mismatch_count), 32'd255);
    chk("t4_sticky", 32'(error_sticky), 32'd1);

    // Reset while FULL
    outs_ready = 0; ins = K; ins_valid = 1; cyc(); cyc();
    chk("t5_full", 32'(ins_ready), 32'd0);
    rst = 1; cyc(); rst = 0; ins_valid = 0; outs_ready = 1;
    chk("t5_valid", 32'(outs_valid), 32'd0);
    chk("t5_rdy", 32'(ins_ready), 32'd1);
    chk("t5_count", 32'(mismatch_count), 32'd0);
    chk("t5_sticky", 32'(error_sticky), 32'd0);
    e0 = emitted;
    cyc(); cyc(); cyc();
    chk("t5_no_emit", 32'(emitted - e0), 32'd0);

    // Random traffic, 10k tokens
    acc_cnt = 0; e0 = emitted; cycles = 0;
    while (acc_cnt < 10000 && cycles < 40000) begin
      ins_valid  = ($urandom_range(3) != 0);
      outs_ready = ($urandom_range(3) != 0);
      if ($urandom_range(9) == 0) ins = K;
      else begin
        ins = $urandom;
        if (ins == K) ins = K ^ 32'h4;
      end
      cyc();
      cycles++;
    end
    chk("t6_budget", 32'(acc_cnt >= 10000), 32'd1);
    ins_valid = 0; outs_ready = 1;
    cyc(); cyc(); cyc();
    chk("t6_emitted", 32'(emitted - e0), 32'(acc_cnt));
    chk("t6_count", 32'(mismatch_count), 32'd255);
    chk("t6_drained", 32'(outs_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
